ttt_processor_engine: RTL and testbench

// Single-clock successor to the token/threshold/timer processor array: NUM_PROCESSORS processors, each

---
 rtl/ttt_pkg.sv | 18 +
 rtl/ttt_event_fifo.sv | 57 +++++
 rtl/ttt_processor_engine.sv | 193 +++++++++++++++++++
 tb/tb_ttt_processor_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the token/threshold/timer processor engine.
// Event type codes and sweep sequencer states.
package ttt_pkg;

    localparam int EV_TYPE_W = 2;

    typedef enum logic [EV_TYPE_W-1:0] {
        EV_NONE  = 2'b00,
        EV_START = 2'b01,
        EV_STOP  = 2'b10
    } ev_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/ttt_event_fifo.sv
// Purpose: first-word fall-through event queue between the sweep sequencer and the serializer.
// Latency: a pushed word is visible on out_vld/out_dat the cycle after the push.
// Backpressure: in_rdy drops only when full and the consumer is not popping in the same cycle.
module ttt_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push, pop;

    assign out_vld = ~empty_q;
    assign out_dat = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    // A pop in the same cycle frees the slot the push lands in.
    assign in_rdy  = ~full_q | out_rdy;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/ttt_processor_engine.sv
// Purpose: processor array accumulating per-channel token deltas; each tick sweeps all processors for START/STOP.
// Latency: a sweep takes NUM_PROCESSORS cycles without stalls; events appear one cycle after their step.
// Backpressure: tok_ready/prog_ready low during a sweep; the sweep stalls while the event FIFO cannot accept.
module ttt_processor_engine
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 16,
    parameter int NUM_CHANNELS   = 2,
    parameter int NEW_TOKEN_BITS = 4,
    parameter int TOKEN_BITS     = 8,
    parameter int DURATION_BITS  = 8,
    parameter int EV_FIFO_DEPTH  = 4,
    localparam int PW            = $clog2(NUM_PROCESSORS),
    localparam int NTB           = NEW_TOKEN_BITS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [NUM_CHANNELS-1:0]    tok_valid,
    output logic                       tok_ready,
    input  logic [NUM_CHANNELS*PW-1:0] tok_id,
    input  logic [NUM_CHANNELS*NTB-1:0] tok_good,
    input  logic [NUM_CHANNELS*NTB-1:0] tok_bad,
    input  logic                       prog_valid,
    output logic                       prog_ready,
    input  logic [PW-1:0]              prog_id,
    input  logic [TOKEN_BITS-1:0]      prog_threshold,
    input  logic [DURATION_BITS-1:0]   prog_duration,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [PW-1:0]              ev_id,
    output logic [1:0]                 ev_type,
    output logic                       busy,
    output logic                       tick_overrun
);
    localparam int SW = TOKEN_BITS + NTB + $clog2(NUM_CHANNELS + 1) + 2;
    localparam int TMAX = (1 << TOKEN_BITS) - 1;
    localparam int EW = PW + EV_TYPE_W;

    logic [TOKEN_BITS-1:0]    good_q [NUM_PROCESSORS];
    logic [TOKEN_BITS-1:0]    bad_q  [NUM_PROCESSORS];
    logic [TOKEN_BITS-1:0]    thr_q  [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] dur_q  [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] rem_q  [NUM_PROCESSORS];
    logic [NUM_PROCESSORS-1:0] active_q;
    logic [TOKEN_BITS-1:0]    good_sum [NUM_PROCESSORS];
    logic [TOKEN_BITS-1:0]    bad_sum  [NUM_PROCESSORS];

    state_t          state_q, state_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic            tick_pending_q, tick_overrun_q;
    logic            start_c, stop_c, ev_push, step, last, done;
    ev_type_t        ev_kind;
    logic            fifo_in_rdy, fifo_full, fifo_empty, fifo_flags_unused;
    logic [EW-1:0]   fifo_out;

    function automatic logic [TOKEN_BITS-1:0] sat(input logic signed [SW-1:0] v);
        if (v < 0)               return '0;
        else if (v > SW'(TMAX))  return TOKEN_BITS'(TMAX);
        else                     return v[TOKEN_BITS-1:0];
    endfunction

    // Full-width accumulation per processor so several channels hitting one ID all count.
    always_comb begin
        logic signed [SW-1:0] g_acc, b_acc;
        g_acc = '0;
        b_acc = '0;
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            g_acc = SW'(good_q[p]);
            b_acc = SW'(bad_q[p]);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (tok_valid[c] && tok_id[c*PW +: PW] == PW'(p)) begin
                    g_acc = g_acc + SW'($signed(tok_good[c*NTB +: NTB]));
                    b_acc = b_acc + SW'($signed(tok_bad[c*NTB +: NTB]));
                end
            end
            good_sum[p] = sat(g_acc);
            bad_sum[p]  = sat(b_acc);
        end
    end

    assign start_c = ~active_q[idx_q] && (dur_q[idx_q] != '0) &&
                     (good_q[idx_q] >= thr_q[idx_q]) && (bad_q[idx_q] == '0);
    assign stop_c  = active_q[idx_q] && ((bad_q[idx_q] != '0) || (rem_q[idx_q] == '0));
    assign ev_kind = start_c ? EV_START : EV_STOP;
    assign ev_push = (state_q == SCAN) && (start_c || stop_c);
    assign step    = (state_q == SCAN) && (!ev_push || fifo_in_rdy);
    assign last    = (idx_q == PW'(NUM_PROCESSORS - 1));
    assign done    = step && last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (step) begin
                    if (last) begin
                        idx_d = '0;
                        if (!(tick_pending_q || tick)) state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // A restart consumes one tick; a tick arriving with one already queued is lost.
            if (state_q == SCAN) begin
                if (done) begin
                    tick_pending_q <= tick_pending_q && tick;
                end else if (tick) begin
                    if (tick_pending_q) tick_overrun_q <= 1'b1;
                    tick_pending_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PROCESSORS; p++) begin
                good_q[p] <= '0;
                bad_q[p]  <= '0;
                thr_q[p]  <= '0;
                dur_q[p]  <= '0;
                rem_q[p]  <= '0;
            end
            active_q <= '0;
        end else if (state_q == IDLE) begin
            for (int p = 0; p < NUM_PROCESSORS; p++) begin
                good_q[p] <= good_sum[p];
                bad_q[p]  <= bad_sum[p];
            end
            if (prog_valid) begin
                thr_q[prog_id] <= prog_threshold;
                dur_q[prog_id] <= prog_duration;
            end
        end else if (step) begin
            good_q[idx_q] <= '0;
            bad_q[idx_q]  <= '0;
            if (start_c) begin
                active_q[idx_q] <= 1'b1;
                rem_q[idx_q]    <= dur_q[idx_q] - 1'b1;
            end else if (stop_c) begin
                active_q[idx_q] <= 1'b0;
            end else if (active_q[idx_q]) begin
                rem_q[idx_q] <= rem_q[idx_q] - 1'b1;
            end
        end
    end

    ttt_event_fifo #(
        .WIDTH (EW),
        .DEPTH (EV_FIFO_DEPTH)
    ) u_ev_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (ev_push),
        .in_rdy  (fifo_in_rdy),
        .in_dat  ({idx_q, ev_kind}),
        .out_vld (ev_valid),
        .out_rdy (ev_ready),
        .out_dat (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_flags_unused = fifo_full ^ fifo_empty;
    assign ev_id        = fifo_out[EW-1:EV_TYPE_W];
    assign ev_type      = fifo_out[EV_TYPE_W-1:0];
    assign tok_ready    = (state_q == IDLE);
    assign prog_ready   = tok_ready;
    assign busy         = (state_q == SCAN);
    assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_ttt_processor_engine.sv
// Directed bench for ttt_processor_engine: start/stop timing, saturation, bad-token stop,
// FIFO backpressure, back-to-back sweeps with overrun, and asynchronous reset mid-sweep.
module tb_ttt_processor_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic [1:0]  tok_valid;
    logic        tok_ready;
    logic [7:0]  tok_id;
    logic [7:0]  tok_good;
    logic [7:0]  tok_bad;
    logic        prog_valid;
    logic        prog_ready;
    logic [3:0]  prog_id;
    logic [7:0]  prog_threshold;
    logic [7:0]  prog_duration;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_id;
    logic [1:0]  ev_type;
    logic        busy;
    logic        tick_overrun;

    int total = 0;
    int bad = 0;
    logic [5:0] evq [$];

    ttt_processor_engine dut (
        .clock          (clock),
        .reset          (reset),
        .tick           (tick),
        .tok_valid      (tok_valid),
        .tok_ready      (tok_ready),
        .tok_id         (tok_id),
        .tok_good       (tok_good),
        .tok_bad        (tok_bad),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .prog_id        (prog_id),
        .prog_threshold (prog_threshold),
        .prog_duration  (prog_duration),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_id          (ev_id),
        .ev_type        (ev_type),
        .busy           (busy),
        .tick_overrun   (tick_overrun)
    );

    always #5 clock = ~clock;

    // Inputs only change #1 after posedge, so a negedge sample sees the coming handshake.
    always @(negedge clock) begin
        if (reset && ev_valid && ev_ready) evq.push_back({ev_id, ev_type});
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        tick = 0; tok_valid = '0; tok_id = '0; tok_good = '0; tok_bad = '0;
        prog_valid = 0; prog_id = '0; prog_threshold = '0; prog_duration = '0;
    endtask

    task automatic prog(input logic [3:0] id, input logic [7:0] thr, input logic [7:0] dur);
        prog_valid = 1; prog_id = id; prog_threshold = thr; prog_duration = dur;
        cyc();
        prog_valid = 0;
    endtask

    task automatic drive(input logic v0, input logic [3:0] id0, input logic [3:0] g0, input logic [3:0] b0,
                         input logic v1, input logic [3:0] id1, input logic [3:0] g1, input logic [3:0] b1,
                         input logic tk);
        tok_valid = {v1, v0}; tok_id = {id1, id0}; tok_good = {g1, g0}; tok_bad = {b1, b0}; tick = tk;
        cyc();
        idle_in();
    endtask

    task automatic do_tick();
        tick = 1;
        cyc();
        tick = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic sweep_and_drain();
        int n;
        do_tick();
        wait_idle(n);
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        total++; if (tok_ready !== 1'b1) begin bad++; $display("FAIL reset_tok_ready: got %b want 1", tok_ready); end
        total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL reset_prog_ready: got %b want 1", prog_ready); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (tick_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", tick_overrun); end
    endtask

    task automatic test_start_stop();
        int n;
        logic [5:0] e;
        prog(4'd3, 8'd5, 8'd2);
        evq.delete();
        drive(1, 4'd3, 4'd3, 4'd0, 1, 4'd3, 4'd2, 4'd0, 1);
        wait_idle(n);
        total++; if (n !== 16) begin bad++; $display("FAIL sweep_len: got %0d want 16", n); end
        repeat (4) cyc();
        total++; if (evq.size() !== 1) begin bad++; $display("FAIL start3_count: got %0d want 1", evq.size()); end
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (e !== {4'd3, 2'b01}) begin bad++; $display("FAIL start3_event: got %h want %h", e, {4'd3, 2'b01}); end
        evq.delete();
        sweep_and_drain();
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL mid_tick_quiet: got %0d events want 0", evq.size()); end
        evq.delete();
        sweep_and_drain();
        total++; if (evq.size() !== 1) begin bad++; $display("FAIL stop3_count: got %0d want 1", evq.size()); end
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (e !== {4'd3, 2'b10}) begin bad++; $display("FAIL stop3_event: got %h want %h", e, {4'd3, 2'b10}); end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        prog(4'd5, 8'd255, 8'd1);
        prog(4'd6, 8'd1, 8'd1);
        repeat (17) drive(1, 4'd5, 4'd7, 4'd0, 1, 4'd5, 4'd7, 4'd0, 0);
        drive(1, 4'd5, 4'd6, 4'd0, 1, 4'd5, 4'd6, 4'd0, 0);
        drive(1, 4'd5, 4'd4, 4'd0, 1, 4'd5, 4'd4, 4'd0, 0);
        drive(1, 4'd6, 4'd3, 4'd0, 0, 4'd0, 4'd0, 4'd0, 0);
        drive(1, 4'd6, 4'b1000, 4'd0, 0, 4'd0, 4'd0, 4'd0, 0);
        evq.delete();
        sweep_and_drain();
        total++; if (evq.size() !== 1) begin bad++; $display("FAIL sat_count: got %0d want 1", evq.size()); end
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (e !== {4'd5, 2'b01}) begin bad++; $display("FAIL sat_high_start: got %h want %h", e, {4'd5, 2'b01}); end
        evq.delete();
        sweep_and_drain();
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (evq.size() !== 1 || e !== {4'd5, 2'b10}) begin bad++; $display("FAIL sat_stop5: got n=%0d e=%h want n=1 e=%h", evq.size(), e, {4'd5, 2'b10}); end
    endtask

    task automatic test_bad_stop();
        int n;
        logic [5:0] e;
        prog(4'd1, 8'd1, 8'd5);
        evq.delete();
        drive(1, 4'd1, 4'd1, 4'd0, 0, 4'd0, 4'd0, 4'd0, 1);
        wait_idle(n);
        repeat (4) cyc();
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (evq.size() !== 1 || e !== {4'd1, 2'b01}) begin bad++; $display("FAIL start1: got n=%0d e=%h want n=1 e=%h", evq.size(), e, {4'd1, 2'b01}); end
        evq.delete();
        drive(1, 4'd1, 4'd2, 4'd1, 0, 4'd0, 4'd0, 4'd0, 1);
        wait_idle(n);
        repeat (4) cyc();
        total++; if (evq.size() !== 1) begin bad++; $display("FAIL bad_stop_count: got %0d want 1", evq.size()); end
        e = (evq.size() > 0) ? evq[0] : 6'h3f;
        total++; if (e !== {4'd1, 2'b10}) begin bad++; $display("FAIL bad_stop_event: got %h want %h", e, {4'd1, 2'b10}); end
        evq.delete();
        sweep_and_drain();
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL no_rearm: got %0d events want 0", evq.size()); end
    endtask

    task automatic test_backpressure();
        int n;
        logic [5:0] e;
        for (int i = 8; i < 16; i++) prog(4'(i), 8'd1, 8'd1);
        for (int i = 8; i < 16; i += 2) drive(1, 4'(i), 4'd1, 4'd0, 1, 4'(i + 1), 4'd1, 4'd0, 0);
        ev_ready = 0;
        evq.delete();
        do_tick();
        repeat (30) cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL stall_ev_valid: got %b want 1", ev_valid); end
        total++; if (tok_ready !== 1'b0) begin bad++; $display("FAIL stall_tok_ready: got %b want 0", tok_ready); end
        ev_ready = 1;
        wait_idle(n);
        repeat (4) cyc();
        total++; if (evq.size() !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", evq.size()); end
        for (int i = 0; i < 8; i++) begin
            e = (i < evq.size()) ? evq[i] : 6'h3f;
            total++;
            if (e !== {4'(8 + i), 2'b01}) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, e, {4'(8 + i), 2'b01}); end
        end
        evq.delete();
        sweep_and_drain();
        total++; if (evq.size() !== 8) begin bad++; $display("FAIL bp_stops: got %0d want 8", evq.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        evq.delete();
        do_tick();
        repeat (3) cyc();
        do_tick();
        total++; if (tick_overrun !== 1'b0) begin bad++; $display("FAIL pending_no_overrun: got %b want 0", tick_overrun); end
        do_tick();
        total++; if (tick_overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", tick_overrun); end
        wait_idle(n);
        total++; if (n !== 27) begin bad++; $display("FAIL b2b_busy_len: got %0d want 27", n); end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 8; i < 16; i += 2) drive(1, 4'(i), 4'd1, 4'd0, 1, 4'(i + 1), 4'd1, 4'd0, 0);
        ev_ready = 0;
        evq.delete();
        do_tick();
        repeat (20) cyc();
        total++; if (busy !== 1'b1 || ev_valid !== 1'b1) begin bad++; $display("FAIL pre_reset: busy=%b ev_valid=%b want 1 1", busy, ev_valid); end
        #2 reset = 0;
        #1;
        test_reset();
        repeat (2) cyc();
        reset = 1;
        ev_ready = 1;
        repeat (3) cyc();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL post_reset_ev_valid: got %b want 0", ev_valid); end
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL post_reset_events: got %0d want 0", evq.size()); end
    endtask

    initial begin
        reset = 0;
        ev_ready = 1;
        idle_in();
        repeat (3) @(posedge clock);
        #1 reset = 1;
        cyc();
        test_reset();
        test_start_stop();
        test_saturation();
        test_bad_stop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
